// File: rtl/nibble_add_sequencer.sv
// Multi-cycle W-bit add/subtract that walks one shared 4-bit adder across the operand nibbles.
// Optional macro NIBBLE_ADD_OVF_EN adds a registered signed-overflow output ovf.

module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] total;

  assign total = 5'(a) + 5'(b) + 5'(ci);
  assign s     = total[3:0];
  assign co    = total[4];
endmodule

module nibble_add_sequencer #(
  parameter int unsigned NIBBLES = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   start_ready,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   busy
`ifdef NIBBLE_ADD_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   idx, idx_next;
  logic            carry, carry_next;
  logic [W-1:0]    a_q, a_q_next;
  logic [W-1:0]    b_q, b_q_next;
  logic [W-1:0]    sum_next;
  logic            cout_next;
  logic [3:0]      add_a, add_b, add_s;
  logic            add_co;
`ifdef NIBBLE_ADD_OVF_EN
  logic            ovf_next;
`endif

  // The only adder on the datapath; it is time-shared across all nibbles.
  four_bit_adder u_four_bit_adder (
    .a  (add_a),
    .b  (add_b),
    .ci (carry),
    .s  (add_s),
    .co (add_co)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    carry_next = carry;
    a_q_next   = a_q;
    b_q_next   = b_q;
    sum_next   = sum;
    cout_next  = cout;
`ifdef NIBBLE_ADD_OVF_EN
    ovf_next   = ovf;
`endif
    add_a      = '0;
    add_b      = '0;

    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx == IW'(i)) begin
        add_a = a_q[4*i +: 4];
        add_b = b_q[4*i +: 4];
      end
    end

    case (state)
      IDLE: begin
        if (start) begin
          a_q_next   = a;
          b_q_next   = sub ? ~b : b;
          carry_next = sub ? 1'b1 : cin;
          idx_next   = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < int'(NIBBLES); i++) begin
          if (idx == IW'(i)) sum_next[4*i +: 4] = add_s;
        end
        carry_next = add_co;
        idx_next   = idx + IW'(1);
        if (idx == IW'(NIBBLES - 1)) begin
          cout_next  = add_co;
`ifdef NIBBLE_ADD_OVF_EN
          ovf_next   = (a_q[W-1] == b_q[W-1]) && (sum_next[W-1] != a_q[W-1]);
`endif
          idx_next   = '0;
          state_next = DONE;
        end
      end

      DONE: begin
        if (res_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // State register; status flags are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum         <= '0;
      cout        <= 1'b0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
`ifdef NIBBLE_ADD_OVF_EN
      ovf         <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      carry       <= carry_next;
      a_q         <= a_q_next;
      b_q         <= b_q_next;
      sum         <= sum_next;
      cout        <= cout_next;
      start_ready <= (state_next == IDLE);
      busy        <= (state_next != IDLE);
      res_valid   <= (state_next == DONE);
`ifdef NIBBLE_ADD_OVF_EN
      ovf         <= ovf_next;
`endif
    end
  end

endmodule
